// File: rtl/find_string_param.sv
// rtl/find_string_param.sv - parametrised string/pattern editor with occurrence-counting search

// Two-flop synchroniser; RST_VAL is the level that must not look like an event after reset.
module find_string_param_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);
  logic meta_q, meta_d;
  logic sync_q, sync_d;

  // next values of the two synchroniser stages
  always_comb begin
    meta_d = din;
    sync_d = meta_q;
  end

  // synchroniser registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign dout = sync_q;
endmodule

module find_string_param #(
  parameter int  SYM_W   = 4,
  parameter int  MAX_LEN = 16,
  parameter int  PAT_MAX = 4,
  localparam int LW      = $clog2(MAX_LEN + 1),
  localparam int PW      = $clog2(PAT_MAX + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [SYM_W-1:0] in_sym,
  input  logic             sel_pat,
  input  logic             overlap,
  input  logic             submit,
  input  logic             delete,
  input  logic             roll_back,
  input  logic             done,
  output logic [LW-1:0]    str_len,
  output logic [PW-1:0]    pat_len,
  output logic [SYM_W-1:0] last_sym,
  output logic             busy,
  output logic             valid,
  output logic [LW-1:0]    match_cnt,
  output logic [LW-1:0]    first_pos,
  output logic             err
);
  localparam int LW1 = LW + 1;
  localparam int AW  = $clog2(MAX_LEN);
  localparam int PA  = (PAT_MAX > 1) ? $clog2(PAT_MAX) : 1;

  localparam logic OP_SUBMIT = 1'b0;
  localparam logic OP_DELETE = 1'b1;
  localparam logic BUF_STR   = 1'b0;
  localparam logic BUF_PAT   = 1'b1;

  typedef enum logic [1:0] {S_IDLE, S_CMP, S_FIN} state_t;

  state_t state_q, state_d;

  logic [SYM_W-1:0] str_mem_q [MAX_LEN];
  logic [SYM_W-1:0] str_mem_d [MAX_LEN];
  logic [SYM_W-1:0] pat_mem_q [PAT_MAX];
  logic [SYM_W-1:0] pat_mem_d [PAT_MAX];
  logic [LW-1:0]    str_len_q, str_len_d;
  logic [PW-1:0]    pat_len_q, pat_len_d;

  logic             undo_valid_q, undo_valid_d;
  logic             undo_buf_q, undo_buf_d;
  logic             undo_op_q, undo_op_d;
  logic [SYM_W-1:0] undo_sym_q, undo_sym_d;

  logic [LW-1:0]    p_q, p_d;
  logic [PW-1:0]    k_q, k_d;
  logic [LW-1:0]    cnt_q, cnt_d;
  logic             ovl_q, ovl_d;

  logic             busy_q, busy_d;
  logic             valid_q, valid_d;
  logic [LW-1:0]    match_cnt_q, match_cnt_d;
  logic [LW-1:0]    first_pos_q, first_pos_d;
  logic             err_q, err_d;

  // keys are idle-high, done is idle-low; previous synced level for edge detection
  logic [2:0]       key_prev_q, key_prev_d;
  logic             done_prev_q, done_prev_d;

  logic             sub_s, del_s, rb_s, done_s;
  logic             sub_pulse, del_pulse, rb_pulse, done_rise, any_key;

  logic [LW-1:0]    str_last_w, cmp_idx_w, p_next;
  logic [PW-1:0]    pat_last_w;
  logic [AW-1:0]    str_wr_idx, str_last_idx, str_cmp_idx;
  logic [PA-1:0]    pat_wr_idx, pat_last_idx, pat_cmp_idx;
  logic             legal_edit, step;

  // Keys reset to their pressed level and done to its high level, so a level
  // held across reset release never produces a press or a search start.
  find_string_param_sync #(.RST_VAL(1'b0)) u_sync_sub  (.clk(clk), .rst_n(reset), .din(submit),    .dout(sub_s));
  find_string_param_sync #(.RST_VAL(1'b0)) u_sync_del  (.clk(clk), .rst_n(reset), .din(delete),    .dout(del_s));
  find_string_param_sync #(.RST_VAL(1'b0)) u_sync_rb   (.clk(clk), .rst_n(reset), .din(roll_back), .dout(rb_s));
  find_string_param_sync #(.RST_VAL(1'b1)) u_sync_done (.clk(clk), .rst_n(reset), .din(done),      .dout(done_s));

  assign sub_pulse = key_prev_q[0] & ~sub_s;
  assign del_pulse = key_prev_q[1] & ~del_s;
  assign rb_pulse  = key_prev_q[2] & ~rb_s;
  assign done_rise = ~done_prev_q & done_s;
  assign any_key   = sub_pulse | del_pulse | rb_pulse;

  assign str_last_w   = str_len_q - LW'(1);
  assign pat_last_w   = pat_len_q - PW'(1);
  assign cmp_idx_w    = p_q + LW'(k_q);
  assign str_wr_idx   = str_len_q[AW-1:0];
  assign str_last_idx = str_last_w[AW-1:0];
  assign str_cmp_idx  = cmp_idx_w[AW-1:0];
  assign pat_wr_idx   = pat_len_q[PA-1:0];
  assign pat_last_idx = pat_last_w[PA-1:0];
  assign pat_cmp_idx  = k_q[PA-1:0];

  // edge-detector history
  always_comb begin
    key_prev_d  = {rb_s, del_s, sub_s};
    done_prev_d = done_s;
  end

  // edits while idle, search scan, and result/err bookkeeping
  always_comb begin
    state_d      = state_q;
    str_mem_d    = str_mem_q;
    pat_mem_d    = pat_mem_q;
    str_len_d    = str_len_q;
    pat_len_d    = pat_len_q;
    undo_valid_d = undo_valid_q;
    undo_buf_d   = undo_buf_q;
    undo_op_d    = undo_op_q;
    undo_sym_d   = undo_sym_q;
    p_d          = p_q;
    k_d          = k_q;
    cnt_d        = cnt_q;
    ovl_d        = ovl_q;
    busy_d       = busy_q;
    valid_d      = valid_q;
    match_cnt_d  = match_cnt_q;
    first_pos_d  = first_pos_q;
    err_d        = err_q;
    legal_edit   = 1'b0;
    step         = 1'b0;
    p_next       = p_q;

    case (state_q)
      S_IDLE: begin
        if (done_rise) begin
          if (pat_len_q == '0) begin
            err_d = 1'b1;
          end else begin
            // a key pressed in the very cycle of the start is dropped as if busy
            err_d       = any_key;
            valid_d     = 1'b0;
            match_cnt_d = '0;
            first_pos_d = LW'(MAX_LEN);
            cnt_d       = '0;
            p_d         = '0;
            k_d         = '0;
            ovl_d       = overlap;
            if (LW'(pat_len_q) > str_len_q) begin
              state_d = S_FIN;
            end else begin
              state_d = S_CMP;
              busy_d  = 1'b1;
            end
          end
        end else if (rb_pulse) begin
          if (undo_valid_q) begin
            legal_edit   = 1'b1;
            undo_valid_d = 1'b0;
            if (undo_buf_q == BUF_PAT) begin
              if (undo_op_q == OP_SUBMIT) begin
                pat_len_d = pat_len_q - PW'(1);
              end else begin
                pat_mem_d[pat_wr_idx] = undo_sym_q;
                pat_len_d             = pat_len_q + PW'(1);
              end
            end else begin
              if (undo_op_q == OP_SUBMIT) begin
                str_len_d = str_len_q - LW'(1);
              end else begin
                str_mem_d[str_wr_idx] = undo_sym_q;
                str_len_d             = str_len_q + LW'(1);
              end
            end
          end else begin
            err_d = 1'b1;
          end
        end else if (del_pulse) begin
          if (sel_pat) begin
            if (pat_len_q != '0) begin
              legal_edit   = 1'b1;
              pat_len_d    = pat_last_w;
              undo_valid_d = 1'b1;
              undo_buf_d   = BUF_PAT;
              undo_op_d    = OP_DELETE;
              undo_sym_d   = pat_mem_q[pat_last_idx];
            end else begin
              err_d = 1'b1;
            end
          end else begin
            if (str_len_q != '0) begin
              legal_edit   = 1'b1;
              str_len_d    = str_last_w;
              undo_valid_d = 1'b1;
              undo_buf_d   = BUF_STR;
              undo_op_d    = OP_DELETE;
              undo_sym_d   = str_mem_q[str_last_idx];
            end else begin
              err_d = 1'b1;
            end
          end
        end else if (sub_pulse) begin
          if (sel_pat) begin
            if (pat_len_q < PW'(PAT_MAX)) begin
              legal_edit            = 1'b1;
              pat_mem_d[pat_wr_idx] = in_sym;
              pat_len_d             = pat_len_q + PW'(1);
              undo_valid_d          = 1'b1;
              undo_buf_d            = BUF_PAT;
              undo_op_d             = OP_SUBMIT;
            end else begin
              err_d = 1'b1;
            end
          end else begin
            if (str_len_q < LW'(MAX_LEN)) begin
              legal_edit            = 1'b1;
              str_mem_d[str_wr_idx] = in_sym;
              str_len_d             = str_len_q + LW'(1);
              undo_valid_d          = 1'b1;
              undo_buf_d            = BUF_STR;
              undo_op_d             = OP_SUBMIT;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        if (legal_edit) begin
          err_d       = 1'b0;
          valid_d     = 1'b0;
          match_cnt_d = '0;
          first_pos_d = LW'(MAX_LEN);
        end
      end

      S_CMP: begin
        if (any_key || done_rise) err_d = 1'b1;
        if (str_mem_q[str_cmp_idx] == pat_mem_q[pat_cmp_idx]) begin
          if (k_q == pat_last_w) begin
            cnt_d = cnt_q + LW'(1);
            if (cnt_q == '0) first_pos_d = p_q;
            p_next = ovl_q ? (p_q + LW'(1)) : (p_q + LW'(pat_len_q));
            step   = 1'b1;
          end else begin
            k_d = k_q + PW'(1);
          end
        end else begin
          p_next = p_q + LW'(1);
          step   = 1'b1;
        end
        // stop once the next window would run past the end of the string
        if (step) begin
          p_d = p_next;
          k_d = '0;
          if ((LW1'(p_next) + LW1'(pat_len_q)) > LW1'(str_len_q)) state_d = S_FIN;
        end
      end

      S_FIN: begin
        if (any_key || done_rise) err_d = 1'b1;
        match_cnt_d = cnt_q;
        busy_d      = 1'b0;
        valid_d     = 1'b1;
        state_d     = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // state registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      str_mem_q    <= '{default: '0};
      pat_mem_q    <= '{default: '0};
      str_len_q    <= '0;
      pat_len_q    <= '0;
      undo_valid_q <= 1'b0;
      undo_buf_q   <= BUF_STR;
      undo_op_q    <= OP_SUBMIT;
      undo_sym_q   <= '0;
      p_q          <= '0;
      k_q          <= '0;
      cnt_q        <= '0;
      ovl_q        <= 1'b0;
      busy_q       <= 1'b0;
      valid_q      <= 1'b0;
      match_cnt_q  <= '0;
      first_pos_q  <= LW'(MAX_LEN);
      err_q        <= 1'b0;
      key_prev_q   <= 3'b000;
      done_prev_q  <= 1'b1;
    end else begin
      state_q      <= state_d;
      str_mem_q    <= str_mem_d;
      pat_mem_q    <= pat_mem_d;
      str_len_q    <= str_len_d;
      pat_len_q    <= pat_len_d;
      undo_valid_q <= undo_valid_d;
      undo_buf_q   <= undo_buf_d;
      undo_op_q    <= undo_op_d;
      undo_sym_q   <= undo_sym_d;
      p_q          <= p_d;
      k_q          <= k_d;
      cnt_q        <= cnt_d;
      ovl_q        <= ovl_d;
      busy_q       <= busy_d;
      valid_q      <= valid_d;
      match_cnt_q  <= match_cnt_d;
      first_pos_q  <= first_pos_d;
      err_q        <= err_d;
      key_prev_q   <= key_prev_d;
      done_prev_q  <= done_prev_d;
    end
  end

  // last symbol of whichever buffer is currently selected for editing
  always_comb begin
    last_sym = '0;
    if (sel_pat) begin
      if (pat_len_q != '0) last_sym = pat_mem_q[pat_last_idx];
    end else begin
      if (str_len_q != '0) last_sym = str_mem_q[str_last_idx];
    end
  end

  assign str_len   = str_len_q;
  assign pat_len   = pat_len_q;
  assign busy      = busy_q;
  assign valid     = valid_q;
  assign match_cnt = match_cnt_q;
  assign first_pos = first_pos_q;
  assign err       = err_q;
endmodule

// File: tb/tb_find_string_param.sv
// tb/tb_find_string_param.sv - randomized self-checking bench for find_string_param
module tb_find_string_param;
  localparam int SYM_W   = 4;
  localparam int MAX_LEN = 16;
  localparam int PAT_MAX = 4;
  localparam int LW      = 5;
  localparam int PW      = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic [SYM_W-1:0] in_sym;
  logic             sel_pat, overlap, submit, delete, roll_back, done;
  logic [LW-1:0]    str_len, match_cnt, first_pos;
  logic [PW-1:0]    pat_len;
  logic [SYM_W-1:0] last_sym;
  logic             busy, valid, err;

  always #5 clk = ~clk;

  find_string_param #(.SYM_W(SYM_W), .MAX_LEN(MAX_LEN), .PAT_MAX(PAT_MAX)) dut (
    .clk(clk), .reset(reset), .in_sym(in_sym), .sel_pat(sel_pat), .overlap(overlap),
    .submit(submit), .delete(delete), .roll_back(roll_back), .done(done),
    .str_len(str_len), .pat_len(pat_len), .last_sym(last_sym), .busy(busy),
    .valid(valid), .match_cnt(match_cnt), .first_pos(first_pos), .err(err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // reference model
  logic [3:0] str_m[$];
  logic [3:0] pat_m[$];
  bit         um_valid, um_pat, um_del;
  logic [3:0] um_sym;
  bit         err_m, valid_m;
  int         cnt_m, first_m;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic void model_clear();
    str_m.delete();
    pat_m.delete();
    um_valid = 0; um_pat = 0; um_del = 0; um_sym = '0;
    err_m = 0; valid_m = 0; cnt_m = 0; first_m = MAX_LEN;
  endfunction

  function automatic int exp_last(input bit sel);
    if (sel) return (pat_m.size() > 0) ? int'(pat_m[$]) : 0;
    return (str_m.size() > 0) ? int'(str_m[$]) : 0;
  endfunction

  // count windows of the string equal to the pattern, sliding by 1 or by the pattern length after a hit
  function automatic void model_search(input bit ovl, output int cnt, output int first);
    int  p;
    bit  hit;
    cnt = 0; first = MAX_LEN; p = 0;
    while (p + pat_m.size() <= str_m.size()) begin
      hit = 1;
      for (int j = 0; j < pat_m.size(); j++) if (str_m[p + j] != pat_m[j]) hit = 0;
      if (hit) begin
        if (cnt == 0) first = p;
        cnt++;
        p += ovl ? 1 : pat_m.size();
      end else begin
        p++;
      end
    end
  endfunction

  task automatic model_edit(input int op, input bit sel, input logic [3:0] sym);
    bit legal;
    legal = 0;
    if (op == 2) begin
      if (um_valid) begin
        legal = 1; um_valid = 0;
        if (um_pat) begin
          if (um_del) pat_m.push_back(um_sym); else void'(pat_m.pop_back());
        end else begin
          if (um_del) str_m.push_back(um_sym); else void'(str_m.pop_back());
        end
      end
    end else if (op == 1) begin
      if (sel && pat_m.size() > 0) begin
        legal = 1; um_valid = 1; um_pat = 1; um_del = 1; um_sym = pat_m.pop_back();
      end else if (!sel && str_m.size() > 0) begin
        legal = 1; um_valid = 1; um_pat = 0; um_del = 1; um_sym = str_m.pop_back();
      end
    end else begin
      if (sel && pat_m.size() < PAT_MAX) begin
        legal = 1; pat_m.push_back(sym); um_valid = 1; um_pat = 1; um_del = 0;
      end else if (!sel && str_m.size() < MAX_LEN) begin
        legal = 1; str_m.push_back(sym); um_valid = 1; um_pat = 0; um_del = 0;
      end
    end
    if (legal) begin
      err_m = 0; valid_m = 0; cnt_m = 0; first_m = MAX_LEN;
    end else begin
      err_m = 1;
    end
  endtask

  task automatic check_state(input string tag);
    check_eq({tag, ":str_len"}, int'(str_len), str_m.size());
    check_eq({tag, ":pat_len"}, int'(pat_len), pat_m.size());
    check_eq({tag, ":err"}, int'(err), int'(err_m));
    check_eq({tag, ":valid"}, int'(valid), int'(valid_m));
    check_eq({tag, ":busy"}, int'(busy), 0);
    check_eq({tag, ":last_sym"}, int'(last_sym), exp_last(sel_pat));
    check_eq({tag, ":match_cnt"}, int'(match_cnt), cnt_m);
    check_eq({tag, ":first_pos"}, int'(first_pos), first_m);
  endtask

  // op: 0 submit, 1 delete, 2 roll_back
  task automatic press(input int op, input bit sel, input logic [3:0] sym, input string tag);
    @(negedge clk);
    sel_pat = sel; in_sym = sym;
    case (op)
      0:       submit = 0;
      1:       delete = 0;
      default: roll_back = 0;
    endcase
    repeat (5) @(negedge clk);
    submit = 1; delete = 1; roll_back = 1;
    repeat (3) @(negedge clk);
    model_edit(op, sel, sym);
    check_state(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 0;
    repeat (3) @(negedge clk);
    reset = 1;
    model_clear();
    repeat (3) @(negedge clk);
  endtask

  task automatic run_search(input bit ovl, input bit press_during, input string tag);
    int ec, ef, nb, worst, s, p;
    bit seen_low, got;
    s = str_m.size(); p = pat_m.size();
    @(negedge clk);
    overlap = ovl; done = 1;
    if (p == 0) begin
      repeat (8) @(negedge clk);
      err_m = 1;
      check_eq({tag, ":err"}, int'(err), 1);
      check_eq({tag, ":valid"}, int'(valid), int'(valid_m));
      check_eq({tag, ":busy"}, int'(busy), 0);
    end else begin
      model_search(ovl, ec, ef);
      nb = 0; seen_low = 0; got = 0;
      for (int i = 0; i < 300; i++) begin
        @(negedge clk);
        if (press_during && i == 0) begin sel_pat = 0; in_sym = 4'h5; submit = 0; end
        if (press_during && i == 5) submit = 1;
        if (busy) nb++;
        if (!valid) seen_low = 1;
        else if (seen_low) begin got = 1; break; end
      end
      submit = 1;
      check_eq({tag, ":result_arrived"}, int'(got), 1);
      valid_m = 1; cnt_m = ec; first_m = ef; err_m = press_during;
      check_eq({tag, ":match_cnt"}, int'(match_cnt), ec);
      check_eq({tag, ":first_pos"}, int'(first_pos), ef);
      check_eq({tag, ":valid"}, int'(valid), 1);
      check_eq({tag, ":err"}, int'(err), int'(err_m));
      check_eq({tag, ":busy_after"}, int'(busy), 0);
      check_eq({tag, ":str_len"}, int'(str_len), s);
      check_eq({tag, ":pat_len"}, int'(pat_len), p);
      worst = (s - p + 1) * p + 2;
      if (p > s) check_eq({tag, ":busy_cycles"}, nb, 0);
      else check_eq({tag, ":busy_cycles_in_bound"}, int'(nb >= 1 && nb <= worst), 1);
    end
    done = 0;
    repeat (4) @(negedge clk);
  endtask

  task automatic reset_mid_search();
    int waited;
    waited = 0;
    @(negedge clk);
    overlap = 1; done = 1;
    while (!busy && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check_eq("midrst:busy_seen", int'(busy), 1);
    @(negedge clk);
    check_eq("midrst:still_busy", int'(busy), 1);
    reset = 0;
    #1;
    check_eq("midrst:busy", int'(busy), 0);
    check_eq("midrst:str_len", int'(str_len), 0);
    check_eq("midrst:pat_len", int'(pat_len), 0);
    check_eq("midrst:valid", int'(valid), 0);
    check_eq("midrst:first_pos", int'(first_pos), MAX_LEN);
    check_eq("midrst:err", int'(err), 0);
    done = 0;
    repeat (3) @(negedge clk);
    reset = 1;
    model_clear();
    repeat (3) @(negedge clk);
    check_state("midrst_after");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] r;
    logic [3:0] saved;
    int op;
    bit sel;

    submit = 0; delete = 1; roll_back = 1; done = 0; overlap = 0;
    sel_pat = 0; in_sym = '0; reset = 1;
    #2 reset = 0;
    repeat (4) @(negedge clk);
    reset = 1;
    model_clear();
    repeat (5) @(negedge clk);
    check_state("rst_hold");
    submit = 1;
    repeat (4) @(negedge clk);
    check_state("rst_release");
    check_eq("rst:first_pos_16", int'(first_pos), 16);

    // A,A,A,B against A,A
    press(0, 0, 4'hA, "aaab_s0");
    press(0, 0, 4'hA, "aaab_s1");
    press(0, 0, 4'hA, "aaab_s2");
    press(0, 0, 4'hB, "aaab_s3");
    press(0, 1, 4'hA, "aaab_p0");
    press(0, 1, 4'hA, "aaab_p1");
    run_search(1, 0, "aaab_ovl");
    check_eq("aaab_ovl:cnt2", int'(match_cnt), 2);
    check_eq("aaab_ovl:first0", int'(first_pos), 0);
    run_search(0, 0, "aaab_novl");
    check_eq("aaab_novl:cnt1", int'(match_cnt), 1);

    // full string, delete and undo
    do_reset();
    for (int i = 0; i < MAX_LEN; i++) begin
      r = 4'($urandom_range(0, 15));
      press(0, 0, r, "fill");
    end
    press(0, 0, 4'h7, "full_submit");
    check_eq("full_submit:err1", int'(err), 1);
    check_eq("full_submit:len16", int'(str_len), 16);
    saved = str_m[$];
    press(1, 0, 4'h0, "full_delete");
    check_eq("full_delete:len15", int'(str_len), 15);
    press(2, 0, 4'h0, "undo_delete");
    check_eq("undo_delete:len16", int'(str_len), 16);
    check_eq("undo_delete:sym", int'(last_sym), int'(saved));
    press(2, 0, 4'h0, "undo_twice");
    check_eq("undo_twice:err1", int'(err), 1);

    // pattern longer than string, then empty pattern
    do_reset();
    press(0, 0, 4'h1, "short_s0");
    press(0, 0, 4'h2, "short_s1");
    for (int i = 0; i < 3; i++) press(0, 1, 4'h1, "short_p");
    run_search(1, 0, "short");
    check_eq("short:cnt0", int'(match_cnt), 0);
    check_eq("short:first16", int'(first_pos), 16);
    for (int i = 0; i < 3; i++) press(1, 1, 4'h0, "pat_clear");
    run_search(0, 0, "nopat");
    check_eq("nopat:valid0", int'(valid), 0);

    // press during a search
    do_reset();
    for (int i = 0; i < MAX_LEN; i++) press(0, 0, ($urandom_range(0, 1) != 0) ? 4'hA : 4'hB, "busy_fill");
    for (int i = 0; i < PAT_MAX; i++) press(0, 1, ($urandom_range(0, 1) != 0) ? 4'hA : 4'hB, "busy_pat");
    run_search($urandom_range(0, 1) != 0, 1, "busy_press");

    // roll_back and submit together: only the undo happens
    @(negedge clk);
    sel_pat = 0; in_sym = 4'hC; roll_back = 0; submit = 0;
    repeat (5) @(negedge clk);
    roll_back = 1; submit = 1;
    repeat (3) @(negedge clk);
    model_edit(2, 0, 4'hC);
    check_state("simul");
    check_eq("simul:str_len16", int'(str_len), 16);

    reset_mid_search();

    // random edits interleaved with searches
    for (int n = 0; n < 300; n++) begin
      op  = $urandom_range(0, 3);
      if (op == 3) op = 0;
      sel = ($urandom_range(0, 2) == 0);
      r   = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
          : (($urandom_range(0, 1) != 0) ? 4'hA : 4'hB);
      press(op, sel, r, "rnd_edit");
      if ($urandom_range(0, 5) == 0) run_search($urandom_range(0, 1) != 0, 0, "rnd_search");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
